// File: rtl/sobel_frame_ctrl.sv
// Frame-synchronous output selector for a Sobel/Scharr edge filter.
// Applies mode changes only at frame boundaries and counts edge pixels per frame.
module sobel_frame_ctrl #(
  parameter int LAT   = 4,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic [9:0]  x_coor,
  input  logic [8:0]  y_coor,
  input  logic [11:0] gray_in,
  input  logic [11:0] sobel_out,
  input  logic [11:0] scharr_out,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_mode,
  output logic        cfg_ack,
  output logic [1:0]  active_mode,
  output logic [11:0] pix_out,
  output logic        pix_de,
  output logic        frame_start,
  output logic [18:0] edge_count,
  output logic        count_valid,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [10:0] H_LIM   = 11'(H_ACT);
  localparam logic [9:0]  V_LIM   = 10'(V_ACT);
  localparam logic [18:0] CNT_MAX = 19'h7FFFF;
  localparam logic [11:0] EDGE    = 12'hFFF;

  state_e               state_q, state_d;
  logic [1:0]           staged_q, staged_d;
  logic                 seen_q, seen_d;
  logic [1:0]           active_q, active_d;
  logic                 ack_q, ack_d;
  logic                 fs_q, fs_d;
  logic                 cv_q, cv_d;
  logic [18:0]          cnt_q, cnt_d;
  logic [18:0]          edge_count_q, edge_count_d;
  logic [LAT-1:0]       de_pipe_q, de_pipe_d;
  logic [LAT-1:0][11:0] gray_pipe_q, gray_pipe_d;
  logic [LAT-1:0][1:0]  mode_pipe_q, mode_pipe_d;
  logic [11:0]          pix_q, pix_d;
  logic                 pix_de_q, pix_de_d;

  logic        in_act, fs_det, close;
  logic        d_de, is_edge;
  logic [11:0] d_gray, edge_src;
  logic [1:0]  d_mode;

  // Pixels outside the active window are treated as blanking.
  assign in_act = de && ({1'b0, x_coor} < H_LIM) && ({1'b0, y_coor} < V_LIM);
  assign fs_det = in_act && (x_coor == 10'd0) && (y_coor == 9'd0);

  // cfg_valid is a one-cycle request with no back-pressure: it is always
  // accepted, the last request before a frame start wins, and cfg_ack pulses
  // (with frame_start) in the cycle the requested mode becomes active_mode.
  always_comb begin
    state_d  = state_q;
    staged_d = staged_q;
    seen_d   = seen_q;
    active_d = active_q;
    ack_d    = 1'b0;
    close    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          staged_d = cfg_mode;
          seen_d   = 1'b1;
        end
        if (fs_det) begin
          active_d = staged_q;
          ack_d    = seen_q;
          seen_d   = 1'b0;
          state_d  = cfg_valid ? PEND : RUN;
        end
      end
      RUN: begin
        close = fs_det;
        if (cfg_valid) begin
          staged_d = cfg_mode;
          state_d  = PEND;
        end
      end
      PEND: begin
        close = fs_det;
        if (cfg_valid) staged_d = cfg_mode;
        if (fs_det) begin
          active_d = staged_q;
          ack_d    = 1'b1;
          state_d  = cfg_valid ? PEND : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The mode travels with each pixel so a switch lands exactly on pixel (0,0).
  always_comb begin
    de_pipe_d      = de_pipe_q;
    gray_pipe_d    = gray_pipe_q;
    mode_pipe_d    = mode_pipe_q;
    de_pipe_d[0]   = in_act;
    gray_pipe_d[0] = gray_in;
    mode_pipe_d[0] = active_d;
    for (int i = 1; i < LAT; i++) begin
      de_pipe_d[i]   = de_pipe_q[i-1];
      gray_pipe_d[i] = gray_pipe_q[i-1];
      mode_pipe_d[i] = mode_pipe_q[i-1];
    end
  end

  assign d_de     = de_pipe_q[LAT-1];
  assign d_gray   = gray_pipe_q[LAT-1];
  assign d_mode   = mode_pipe_q[LAT-1];
  assign edge_src = (d_mode == 2'd2) ? scharr_out : sobel_out;
  assign is_edge  = d_de && (edge_src == EDGE);

  always_comb begin
    pix_d    = 12'd0;
    pix_de_d = d_de;
    fs_d     = fs_det;
    cv_d     = close;
    if (d_de) begin
      case (d_mode)
        2'd0:    pix_d = d_gray;
        2'd1:    pix_d = sobel_out;
        2'd2:    pix_d = scharr_out;
        default: pix_d = (sobel_out == EDGE) ? 12'hF00 : d_gray;
      endcase
    end
    edge_count_d = close ? cnt_q : edge_count_q;
    if (fs_det)                           cnt_d = {18'd0, is_edge};
    else if (is_edge && cnt_q != CNT_MAX) cnt_d = cnt_q + 19'd1;
    else                                  cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      staged_q     <= 2'd0;
      seen_q       <= 1'b0;
      active_q     <= 2'd0;
      ack_q        <= 1'b0;
      fs_q         <= 1'b0;
      cv_q         <= 1'b0;
      cnt_q        <= 19'd0;
      edge_count_q <= 19'd0;
      de_pipe_q    <= '0;
      gray_pipe_q  <= '0;
      mode_pipe_q  <= '0;
      pix_q        <= 12'd0;
      pix_de_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      staged_q     <= staged_d;
      seen_q       <= seen_d;
      active_q     <= active_d;
      ack_q        <= ack_d;
      fs_q         <= fs_d;
      cv_q         <= cv_d;
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      de_pipe_q    <= de_pipe_d;
      gray_pipe_q  <= gray_pipe_d;
      mode_pipe_q  <= mode_pipe_d;
      pix_q        <= pix_d;
      pix_de_q     <= pix_de_d;
    end
  end

  assign cfg_ack     = ack_q;
  assign active_mode = active_q;
  assign pix_out     = pix_q;
  assign pix_de      = pix_de_q;
  assign frame_start = fs_q;
  assign edge_count  = edge_count_q;
  assign count_valid = cv_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized scoreboard bench for sobel_frame_ctrl: a frame-level model predicts
// every output pixel and every frame-start event (ack, count, mode).
module tb_sobel_frame_ctrl;

  localparam int LAT    = 4;
  localparam int H_ACT  = 40;
  localparam int V_ACT  = 30;
  localparam int HBLANK = 8;
  localparam int VBLANK = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        de = 1'b0;
  logic [9:0]  x_coor = '0;
  logic [8:0]  y_coor = '0;
  logic [11:0] gray_in = '0;
  logic [11:0] sobel_out = '0;
  logic [11:0] scharr_out = '0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_ack;
  logic [1:0]  active_mode;
  logic [11:0] pix_out;
  logic        pix_de;
  logic        frame_start;
  logic [18:0] edge_count;
  logic        count_valid;
  logic [1:0]  state_dbg;

  sobel_frame_ctrl #(.LAT(LAT), .H_ACT(H_ACT), .V_ACT(V_ACT)) dut (
    .clk(clk), .reset(reset), .de(de), .x_coor(x_coor), .y_coor(y_coor),
    .gray_in(gray_in), .sobel_out(sobel_out), .scharr_out(scharr_out),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack),
    .active_mode(active_mode), .pix_out(pix_out), .pix_de(pix_de),
    .frame_start(frame_start), .edge_count(edge_count),
    .count_valid(count_valid), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        ack;
    logic        cv;
    logic [18:0] cnt;
    logic [1:0]  mode;
  } ev_t;

  logic [11:0] exp_q[$];
  ev_t         ev_q[$];
  logic [23:0] filt_q[$];
  int          checks = 0;
  int          errors = 0;

  // Frame-level reference: a request made before a frame start is applied
  // at that frame start (last one wins); a request on the frame-start cycle
  // waits for the following frame.
  logic [1:0] cur_mode = 2'd0;
  logic [1:0] pend_mode = 2'd0;
  bit         pend = 1'b0;
  bit         started = 1'b0;
  int         frame_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rand_edge();
    return ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'h000;
  endfunction

  function automatic logic [11:0] rand_junk();
    return ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'($urandom);
  endfunction

  task automatic model_frame_start();
    ev_t ev;
    ev.ack  = pend;
    ev.cv   = started;
    ev.cnt  = 19'(frame_edges);
    ev.mode = pend ? pend_mode : cur_mode;
    ev_q.push_back(ev);
    cur_mode    = ev.mode;
    pend        = 1'b0;
    started     = 1'b1;
    frame_edges = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic v, input logic [9:0] x, input logic [8:0] y,
                             input logic [11:0] g, input logic [11:0] sob,
                             input logic [11:0] sch, input logic cv, input logic [1:0] cm);
    logic [23:0] f;
    logic [11:0] e;
    de = v; x_coor = x; y_coor = y; gray_in = g;
    cfg_valid = cv; cfg_mode = cm;
    // Filter stub: results for this pixel appear LAT cycles later.
    filt_q.push_back({sob, sch});
    f = filt_q.pop_front();
    sobel_out = f[23:12];
    scharr_out = f[11:0];
    if (v && x == 10'd0 && y == 9'd0) model_frame_start();
    if (cv) begin
      pend = 1'b1;
      pend_mode = cm;
    end
    if (v) begin
      case (cur_mode)
        2'd0:    e = g;
        2'd1:    e = sob;
        2'd2:    e = sch;
        default: e = (sob == 12'hFFF) ? 12'hF00 : g;
      endcase
      exp_q.push_back(e);
      if (((cur_mode == 2'd2) ? sch : sob) == 12'hFFF) frame_edges++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    drive_cycle(1'b0, 10'($urandom_range(0, 2)), 9'($urandom_range(0, 1)), 12'($urandom),
                rand_junk(), rand_junk(), 1'b0, 2'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pix_out",     32'(pix_out),     32'd0);
    chk("rst_pix_de",      32'(pix_de),      32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_cfg_ack",     32'(cfg_ack),     32'd0);
    chk("rst_count_valid", 32'(count_valid), 32'd0);
    chk("rst_edge_count",  32'(edge_count),  32'd0);
    chk("rst_active_mode", 32'(active_mode), 32'd0);
    chk("rst_state_idle",  32'(state_dbg),   32'(ST_IDLE));
  endtask

  task automatic do_reset();
    if (started) chk("state_pre_reset", 32'(state_dbg), 32'(pend ? ST_PEND : ST_RUN));
    #1;
    reset = 1'b0;
    exp_q.delete();
    ev_q.delete();
    pend = 1'b0; cur_mode = 2'd0; started = 1'b0; frame_edges = 0;
    #1;
    chk_reset_outputs();
    repeat (3) blank();
    reset = 1'b1;
    repeat (LAT + 3) blank();
  endtask

  task automatic drive_frame(input int nlines, input int force_n,
                             input int c1p, input logic [1:0] c1m,
                             input int c2p, input logic [1:0] c2m, input int abort_at);
    int idx = 0;
    logic [11:0] sob;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        if (idx == abort_at) begin
          do_reset();
          return;
        end
        sob = (force_n >= 0) ? ((idx < force_n) ? 12'hFFF : 12'h000) : rand_edge();
        drive_cycle(1'b1, 10'(x), 9'(y), 12'($urandom), sob, rand_edge(),
                    (idx == c1p) || (idx == c2p), (idx == c2p) ? c2m : c1m);
        idx++;
      end
      repeat (HBLANK) blank();
    end
    repeat (VBLANK * (H_ACT + HBLANK)) blank();
  endtask

  // ---------------- monitor ----------------
  logic [11:0] mon_pix;
  ev_t         mon_ev;
  logic [1:0]  prev_mode = 2'd0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_mode = 2'd0;
    end else begin
      if (pix_de) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_extra: got pix_out %0h, expected no pixel", pix_out);
        end else begin
          mon_pix = exp_q.pop_front();
          chk("pix_out", 32'(pix_out), 32'(mon_pix));
        end
      end else if (pix_out != 12'd0) begin
        checks++; errors++;
        $display("FAIL pix_blank: got pix_out %0h with pix_de=0, expected 0", pix_out);
      end
      if (frame_start) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_extra: got frame_start=1, expected none");
        end else begin
          mon_ev = ev_q.pop_front();
          chk("cfg_ack",     32'(cfg_ack),     32'(mon_ev.ack));
          chk("count_valid", 32'(count_valid), 32'(mon_ev.cv));
          chk("active_mode", 32'(active_mode), 32'(mon_ev.mode));
          if (mon_ev.cv) chk("edge_count", 32'(edge_count), 32'(mon_ev.cnt));
        end
      end else if (cfg_ack || count_valid) begin
        checks++; errors++;
        $display("FAIL stray_pulse: got cfg_ack=%0b count_valid=%0b without frame_start, expected 0",
                 cfg_ack, count_valid);
      end
      if (!frame_start && active_mode != prev_mode) begin
        checks++; errors++;
        $display("FAIL mode_change: got active_mode %0d mid-frame, expected %0d", active_mode, prev_mode);
      end
      prev_mode = active_mode;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < LAT; i++) filt_q.push_back(24'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b1;
    repeat (3) blank();

    // Mid-frame pixels after reset must not start the FSM.
    for (int i = 0; i < 6; i++)
      drive_cycle(1'b1, 10'(5 + i), 9'd3, 12'($urandom), rand_edge(), rand_edge(), 1'b0, 2'd0);
    repeat (LAT + 4) blank();
    chk("idle_until_frame_start", 32'(state_dbg), 32'(ST_IDLE));

    drive_frame(V_ACT, -1,   -1, 2'd0,  -1, 2'd0, -1);  // bypass, first frame
    drive_frame(V_ACT, -1,  500, 2'd1,  -1, 2'd0, -1);  // request sobel mid-frame
    drive_frame(V_ACT, 1000, -1, 2'd0,  -1, 2'd0, -1);  // sobel, exactly 1000 edges
    drive_frame(V_ACT, -1,  100, 2'd2, 700, 2'd3, -1);  // last request wins
    drive_frame(V_ACT, -1,    0, 2'd2,  -1, 2'd0, -1);  // overlay; request on frame start
    drive_frame(V_ACT, -1,   -1, 2'd0,  -1, 2'd0, -1);  // scharr
    drive_frame(12,    -1,   -1, 2'd0,  -1, 2'd0, -1);  // short frame
    drive_frame(V_ACT, -1,  300, 2'd0,  -1, 2'd0, 600); // reset with request pending
    drive_frame(V_ACT, -1,   -1, 2'd0,  -1, 2'd0, -1);  // no ack, no count
    drive_frame(V_ACT, -1,   -1, 2'd0,  -1, 2'd0, -1);

    // Request captured while idle is applied at the first frame start.
    do_reset();
    drive_cycle(1'b0, 10'd9, 9'd1, 12'($urandom), rand_junk(), rand_junk(), 1'b1, 2'd2);
    repeat (LAT + 4) blank();
    drive_frame(V_ACT, -1, -1, 2'd0, -1, 2'd0, -1);

    for (int k = 0; k < 2; k++)
      drive_frame(V_ACT, -1, $urandom_range(1, H_ACT * V_ACT - 1), 2'($urandom),
                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, H_ACT * V_ACT - 1) : -1,
                  2'($urandom), -1);
    drive_frame(1, -1, -1, 2'd0, -1, 2'd0, -1);  // closes the last full frame
    repeat (LAT + 6) blank();

    chk("pix_queue_drained",   32'(exp_q.size()), 32'd0);
    chk("frame_queue_drained", 32'(ev_q.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    checks++; errors++;
    $display("FAIL timeout: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
